// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared widths and edge-class codes for the fuzzy edge-detection
// pipeline, plus the threshold-to-class mapping used by the defuzzifier
// scheduler when DEFUZZ_SCHED_CLASSIFY_EN is defined.
package fuzzy_pkg;

  localparam int unsigned MW = 10;  // membership value width
  localparam int unsigned DW = 8;   // crisp value width

  localparam logic [DW-1:0] CLS_STRONG = 8'h00;
  localparam logic [DW-1:0] CLS_WEAK   = 8'h0F;
  localparam logic [DW-1:0] CLS_NONE   = 8'hFF;

  function automatic logic [DW-1:0] classify(input logic [DW-1:0] v,
                                             input logic [DW-1:0] hi,
                                             input logic [DW-1:0] lo);
    if (v >= hi)      return CLS_STRONG;
    else if (v >= lo) return CLS_WEAK;
    else              return CLS_NONE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Grants the first asserted
// eligible bit at or after ptr, wrapping modulo NREQ.
// Ports:
//   eligible  [NREQ]  lanes that may be granted this cycle
//   ptr       [PW]    search start position
//   grant     [NREQ]  one-hot grant (all zero when nothing eligible)
//   grant_idx [PW]    index of the granted lane (0 when no grant)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/defuzz_scheduler.sv
// defuzz_scheduler: shares one external defuzzifier (fixed DFZ_LAT register
// stages) among NREQ pixel lanes. Round-robin issue of registered operands,
// a {valid,lane} tag pipe matched to the datapath latency, and a one-entry
// result buffer per lane with valid/ready backpressure.
// Optional: define DEFUZZ_SCHED_CLASSIFY_EN to map captured results to edge
// classes (>=THR_HI strong, >=THR_LO weak, else none) before buffering.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready [NREQ]    per-lane request handshake
//   req_mmin/mmid/mmax [NREQ*MW]  lane i operands at [MW*i +: MW]
//   dfz_mmin/mmid/mmax [MW]       registered operands to the datapath
//   dfz_defuzzed [DW]             datapath result
//   res_valid/res_ready [NREQ]    per-lane result handshake
//   res_data [NREQ*DW]            lane i result at [DW*i +: DW]
//   busy                          any op in flight or result buffered
module defuzz_scheduler
  import fuzzy_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DFZ_LAT = 0,
  parameter int unsigned THR_HI  = 192,
  parameter int unsigned THR_LO  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*MW-1:0] req_mmin,
  input  logic [NREQ*MW-1:0] req_mmid,
  input  logic [NREQ*MW-1:0] req_mmax,
  output logic [MW-1:0]      dfz_mmin,
  output logic [MW-1:0]      dfz_mmid,
  output logic [MW-1:0]      dfz_mmax,
  input  logic [DW-1:0]      dfz_defuzzed,
  output logic [NREQ-1:0]    res_valid,
  input  logic [NREQ-1:0]    res_ready,
  output logic [NREQ*DW-1:0] res_data,
  output logic               busy
);

  localparam int unsigned PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || DFZ_LAT > 7 || THR_HI > 255 || THR_LO > THR_HI) begin : g_bad_cfg
    $error("defuzz_scheduler: unsupported parameter set");
  end

  logic [NREQ-1:0][MW-1:0] mmin_a, mmid_a, mmax_a;
  assign mmin_a = req_mmin;
  assign mmid_a = req_mmid;
  assign mmax_a = req_mmax;

  logic [NREQ-1:0]           eligible, grant;
  logic [PW-1:0]             grant_idx;
  logic [DW-1:0]             cap_val;

  logic [PW-1:0]             ptr_q, ptr_d;
  logic [NREQ-1:0]           pending_q, pending_d;
  logic [NREQ-1:0]           res_full_q, res_full_d;
  logic [NREQ-1:0][DW-1:0]   res_data_q, res_data_d;
  logic [MW-1:0]             dfz_mmin_q, dfz_mmin_d;
  logic [MW-1:0]             dfz_mmid_q, dfz_mmid_d;
  logic [MW-1:0]             dfz_mmax_q, dfz_mmax_d;
  logic [DFZ_LAT:0]          tag_vld_q, tag_vld_d;
  logic [DFZ_LAT:0][PW-1:0]  tag_lane_q, tag_lane_d;

  // A lane holds at most one operation, in flight or buffered.
  assign eligible = req_valid & ~pending_q & ~res_full_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef DEFUZZ_SCHED_CLASSIFY_EN
  assign cap_val = classify(dfz_defuzzed, DW'(THR_HI), DW'(THR_LO));
`else
  assign cap_val = dfz_defuzzed;
`endif

  always_comb begin
    ptr_d      = ptr_q;
    pending_d  = pending_q;
    res_full_d = res_full_q & ~res_ready;
    res_data_d = res_data_q;
    dfz_mmin_d = dfz_mmin_q;
    dfz_mmid_d = dfz_mmid_q;
    dfz_mmax_d = dfz_mmax_q;
    tag_vld_d  = '0;
    tag_lane_d = '0;

    for (int unsigned s = 1; s <= DFZ_LAT; s++) begin
      tag_vld_d[s]  = tag_vld_q[s-1];
      tag_lane_d[s] = tag_lane_q[s-1];
    end

    if (|grant) begin
      ptr_d                = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      pending_d[grant_idx] = 1'b1;
      dfz_mmin_d           = mmin_a[grant_idx];
      dfz_mmid_d           = mmid_a[grant_idx];
      dfz_mmax_d           = mmax_a[grant_idx];
      tag_vld_d[0]         = 1'b1;
      tag_lane_d[0]        = grant_idx;
    end

    // The captured lane is pending, so it cannot be the lane granted or
    // drained this cycle; the updates above never collide with these.
    if (tag_vld_q[DFZ_LAT]) begin
      res_full_d[tag_lane_q[DFZ_LAT]] = 1'b1;
      pending_d[tag_lane_q[DFZ_LAT]]  = 1'b0;
      res_data_d[tag_lane_q[DFZ_LAT]] = cap_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      pending_q  <= '0;
      res_full_q <= '0;
      res_data_q <= '0;
      dfz_mmin_q <= '0;
      dfz_mmid_q <= '0;
      dfz_mmax_q <= '0;
      tag_vld_q  <= '0;
      tag_lane_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      res_full_q <= res_full_d;
      res_data_q <= res_data_d;
      dfz_mmin_q <= dfz_mmin_d;
      dfz_mmid_q <= dfz_mmid_d;
      dfz_mmax_q <= dfz_mmax_d;
      tag_vld_q  <= tag_vld_d;
      tag_lane_q <= tag_lane_d;
    end
  end

  assign req_ready = grant;
  assign dfz_mmin  = dfz_mmin_q;
  assign dfz_mmid  = dfz_mmid_q;
  assign dfz_mmax  = dfz_mmax_q;
  assign res_valid = res_full_q;
  assign res_data  = res_data_q;
  assign busy      = (|pending_q) | (|res_full_q);

endmodule

// File: tb/tb_defuzz_scheduler.sv
// tb_defuzz_scheduler: directed and randomized stimulus for defuzz_scheduler
// (NREQ=4, DFZ_LAT=2) against a transaction-level reference model that tracks
// each lane's outstanding operation by due cycle. Honours
// DEFUZZ_SCHED_CLASSIFY_EN to match the DUT build.
module tb_defuzz_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned L = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*10-1:0]  req_mmin = '0, req_mmid = '0, req_mmax = '0;
  logic [9:0]       dfz_mmin, dfz_mmid, dfz_mmax;
  logic [7:0]       dfz_defuzzed;
  logic [N-1:0]     res_valid;
  logic [N-1:0]     res_ready = '0;
  logic [N*8-1:0]   res_data;
  logic             busy;

  always #5 clk = ~clk;

  defuzz_scheduler #(
    .NREQ    (N),
    .DFZ_LAT (L),
    .THR_HI  (192),
    .THR_LO  (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mmin     (req_mmin),
    .req_mmid     (req_mmid),
    .req_mmax     (req_mmax),
    .dfz_mmin     (dfz_mmin),
    .dfz_mmid     (dfz_mmid),
    .dfz_mmax     (dfz_mmax),
    .dfz_defuzzed (dfz_defuzzed),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy)
  );

  // Stand-in external defuzzifier: arbitrary arithmetic, L register stages.
  function automatic logic [7:0] dpf(input logic [9:0] a, input logic [9:0] b,
                                     input logic [9:0] c);
    return 8'(b + a - c);
  endfunction

  function automatic logic [7:0] cls(input logic [7:0] v);
`ifdef DEFUZZ_SCHED_CLASSIFY_EN
    if (v >= 8'd192)     return 8'h00;
    else if (v >= 8'd64) return 8'h0F;
    else                 return 8'hFF;
`else
    return v;
`endif
  endfunction

  logic [7:0] dp [L];
  always_ff @(posedge clk) begin
    dp[0] <= dpf(dfz_mmin, dfz_mmid, dfz_mmax);
    for (int k = 1; k < L; k++) dp[k] <= dp[k-1];
  end
  assign dfz_defuzzed = dp[L-1];

  // Reference model state.
  bit         m_inflight [N];
  int         m_due      [N];
  logic [7:0] m_val      [N];
  bit         m_full     [N];
  logic [7:0] m_data     [N];
  int         m_ptr;
  logic [9:0] m_d0, m_d1, m_d2;
  int         cyc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_inflight[i] = 1'b0;
      m_full[i]     = 1'b0;
      m_data[i]     = '0;
      m_due[i]      = 0;
      m_val[i]      = '0;
    end
    m_ptr = 0;
    m_d0 = '0; m_d1 = '0; m_d2 = '0;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the
  // model at the rising edge and let the caller drive new inputs at +1.
  task automatic step();
    int           g;
    int           idx;
    logic [N-1:0] exp_rdy, exp_full;
    logic [N-1:0] rr;
    bit           any;
    logic [9:0]   o0, o1, o2;
    @(negedge clk);
    exp_full = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_full[i] = m_full[i];
      any = any | m_full[i] | m_inflight[i];
    end
    chk("res_valid", 64'(res_valid), 64'(exp_full));
    for (int i = 0; i < N; i++)
      if (m_full[i]) chk($sformatf("res_data[%0d]", i), 64'(res_data[i*8 +: 8]), 64'(m_data[i]));
    chk("busy", 64'(busy), 64'(any));
    chk("dfz_mmin", 64'(dfz_mmin), 64'(m_d0));
    chk("dfz_mmid", 64'(dfz_mmid), 64'(m_d1));
    chk("dfz_mmax", 64'(dfz_mmax), 64'(m_d2));
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx] && !m_inflight[idx] && !m_full[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    rr = res_ready;
    o0 = '0; o1 = '0; o2 = '0;
    if (g >= 0) begin
      o0 = req_mmin[g*10 +: 10];
      o1 = req_mmid[g*10 +: 10];
      o2 = req_mmax[g*10 +: 10];
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++)
        if (m_full[i] && rr[i]) m_full[i] = 1'b0;
      for (int i = 0; i < N; i++)
        if (m_inflight[i] && m_due[i] == cyc) begin
          m_full[i]     = 1'b1;
          m_data[i]     = cls(m_val[i]);
          m_inflight[i] = 1'b0;
        end
      if (g >= 0) begin
        m_inflight[g] = 1'b1;
        m_due[g]      = cyc + 1 + L;
        m_val[g]      = dpf(o0, o1, o2);
        m_d0 = o0; m_d1 = o1; m_d2 = o2;
        m_ptr = (g + 1) % N;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_mmin[i*10 +: 10] = 10'($urandom);
      req_mmid[i*10 +: 10] = 10'($urandom);
      req_mmax[i*10 +: 10] = 10'($urandom);
    end
  endtask

  task automatic set_lane(input int i, input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c);
    req_mmin[i*10 +: 10] = a;
    req_mmid[i*10 +: 10] = b;
    req_mmax[i*10 +: 10] = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    // Power-up reset: DUT state is unknown until the first reset edge.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset.
    repeat (2) step();

    // Single lane: operands (10,200,30) offered for one cycle.
    res_ready = '1;
    set_lane(0, 10'd10, 10'd200, 10'd30);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (6) step();

    // All lanes valid continuously with res_ready high.
    req_valid = '1;
    repeat (30) begin rand_ops(); step(); end

    // Backpressure on lane 1 for 10 cycles.
    res_ready = 4'b1101;
    repeat (10) begin rand_ops(); step(); end
    res_ready = '1;
    repeat (8) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (6) step();

    // Reset mid-flight after grants to lanes 0 and 2.
    do_reset();
    req_valid = 4'b0101;
    rand_ops();
    repeat (2) step();
    do_reset();
    req_valid = '0;
    repeat (6) step();
    req_valid = '1;
    rand_ops();
    step();
    req_valid = '0;
    repeat (6) step();

    // Class boundaries: results 200, 100, 20 plus threshold edges.
    do_reset();
    set_lane(0, 10'd0, 10'd200, 10'd0);
    set_lane(1, 10'd0, 10'd100, 10'd0);
    set_lane(2, 10'd0, 10'd20,  10'd0);
    set_lane(3, 10'd0, 10'd192, 10'd0);
    req_valid = 4'b1111;
    repeat (4) step();
    req_valid = '0;
    repeat (6) step();
    set_lane(0, 10'd0, 10'd191, 10'd0);
    set_lane(1, 10'd0, 10'd64,  10'd0);
    set_lane(2, 10'd0, 10'd63,  10'd0);
    req_valid = 4'b0111;
    repeat (3) step();
    req_valid = '0;
    repeat (6) step();

    // Pointer wrap: ptr sits at 3 with lanes 3 and 0 requesting.
    do_reset();
    rand_ops();
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1001;
    repeat (3) step();
    req_valid = '0;
    repeat (6) step();

    // Randomized traffic with occasional resets.
    repeat (400) begin
      rand_ops();
      req_valid = N'($urandom);
      res_ready = N'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    req_valid = '0;
    res_ready = '1;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
